// File: rtl/buff_uart_pkg.sv
// Shared types for the buffered UART: FSM state encoding, status bit positions, read-path select.
// BUFF_UART_PARITY_EN adds the PARITY state.
package buff_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef BUFF_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    typedef enum logic [1:0] {
        RD_ZERO   = 2'd0,
        RD_RX     = 2'd1,
        RD_STATUS = 2'd2
    } rd_sel_t;

    localparam int STAT_RX_EMPTY    = 0;
    localparam int STAT_RX_FULL     = 1;
    localparam int STAT_TX_EMPTY    = 2;
    localparam int STAT_TX_FULL     = 3;
    localparam int STAT_RX_OVERRUN  = 4;
    localparam int STAT_FRAMING_ERR = 5;
    localparam int STAT_PARITY_ERR  = 6;
    localparam int STAT_TX_OVERFLOW = 7;

endpackage

// File: rtl/buff_uart_fifo.sv
// Synchronous FIFO with registered read data (updated on pop) and push/pop in the same cycle.
module buff_uart_fifo #(
    parameter int width       = 8,
    parameter int fifo_length = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(fifo_length);

    logic [width-1:0] mem [fifo_length];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push, do_pop;

    assign full    = (count_reg == (AW+1)'(fifo_length));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push on a full FIFO needs
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rd_data    <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                rd_data    <= mem[rd_ptr_reg];
            end
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/buff_uart_ctrl.sv
// Register-mapped UART with RX/TX FIFOs, sticky error flags and clear-on-read status.
// Define BUFF_UART_PARITY_EN to add a parity bit (parity_odd selects odd parity).
module buff_uart_ctrl
    import buff_uart_pkg::*;
#(
    parameter int width          = 8,
    parameter int fifo_length    = 16,
    parameter int address_width  = 4,
    parameter int rx_address     = 0,
    parameter int tx_address     = 1,
    parameter int status_address = 2,
    parameter int baud_rate      = 9600,
    parameter int clock_freq     = 460800,
    parameter int stop_bits      = 1
`ifdef BUFF_UART_PARITY_EN
    , parameter bit parity_odd   = 1'b0
`endif
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     rx,
    output logic                     tx,
    input  logic                     read_enable,
    input  logic                     write_enable,
    input  logic [address_width-1:0] active_address,
    input  logic [width-1:0]         data_in,
    output logic [width-1:0]         data_out
);
    localparam int DIV = clock_freq / baud_rate;
    localparam int CW  = $clog2(DIV + 1);
    localparam int BW  = $clog2(width);
    localparam logic [CW-1:0] BIT_END   = CW'(DIV - 1);
    localparam logic [CW-1:0] BIT_MID   = CW'(DIV / 2);
    localparam logic [BW-1:0] LAST_DATA = BW'(width - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(stop_bits - 1);

    logic rx_rd, tx_wr, stat_rd;
    logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_pop, rx_push;
    logic [width-1:0] tx_rd_data, rx_rd_data;

    assign rx_rd   = read_enable && (active_address == address_width'(rx_address));
    assign stat_rd = read_enable && !rx_rd && (active_address == address_width'(status_address));
    assign tx_wr   = write_enable && (active_address == address_width'(tx_address));
    assign rx_pop  = rx_rd && !rx_empty;

    buff_uart_fifo #(.width(width), .fifo_length(fifo_length)) u_tx_fifo (
        .clock(clock), .resetn(resetn), .push(tx_wr), .pop(tx_pop), .wr_data(data_in),
        .rd_data(tx_rd_data), .full(tx_full), .empty(tx_empty));

    // ---------------- transmitter: the popped word stays on rd_data for the whole frame
    uart_state_t     tx_state_reg, tx_state_next;
    logic [CW-1:0]   tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]   tx_bit_reg, tx_bit_next;
    logic            tx_last;

    assign tx_last = (tx_cnt_reg == BIT_END);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_last ? '0 : tx_cnt_reg + CW'(1);
        tx_bit_next   = tx_bit_reg;
        tx_pop        = 1'b0;
        tx            = 1'b1;
        case (tx_state_reg)
            ST_IDLE: begin
                tx_cnt_next = '0;
                if (!tx_empty) begin
                    tx_state_next = ST_START;
                    tx_pop        = 1'b1;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (tx_last) begin
                    tx_state_next = ST_DATA;
                    tx_bit_next   = '0;
                end
            end
            ST_DATA: begin
                tx = tx_rd_data[tx_bit_reg];
                if (tx_last) begin
                    tx_bit_next = tx_bit_reg + BW'(1);
                    if (tx_bit_reg == LAST_DATA) begin
                        tx_bit_next = '0;
`ifdef BUFF_UART_PARITY_EN
                        tx_state_next = ST_PARITY;
`else
                        tx_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef BUFF_UART_PARITY_EN
            ST_PARITY: begin
                tx = (^tx_rd_data) ^ parity_odd;
                if (tx_last) tx_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tx_last) begin
                    tx_bit_next = tx_bit_reg + BW'(1);
                    if (tx_bit_reg == LAST_STOP) begin
                        tx_bit_next = '0;
                        // back-to-back frames: next start bit follows the last stop bit directly
                        if (!tx_empty) begin
                            tx_state_next = ST_START;
                            tx_pop        = 1'b1;
                        end else begin
                            tx_state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase
    end

    // ---------------- receiver
    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg, armed_reg;
    logic [CW-1:0]   idle_cnt_reg;
    uart_state_t     rx_state_reg, rx_state_next;
    logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]   rx_bit_reg, rx_bit_next;
    logic [width-1:0] rx_shift_reg, rx_shift_next;
    logic            rx_ferr_reg, rx_ferr_next, rx_perr_reg, rx_perr_next;
    logic            rx_last, stop_bad, ferr_evt, perr_evt;

    assign rx_last = (rx_cnt_reg == BIT_END);
    assign stop_bad = rx_ferr_reg || !rx_sync_reg;

    // Armed only after one full bit period of idle line following reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            armed_reg    <= 1'b0;
            idle_cnt_reg <= '0;
            rx_state_reg <= ST_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_ferr_reg  <= 1'b0;
            rx_perr_reg  <= 1'b0;
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            if (!armed_reg) begin
                if (!rx_sync_reg)                 idle_cnt_reg <= '0;
                else if (idle_cnt_reg == BIT_END) armed_reg    <= 1'b1;
                else                              idle_cnt_reg <= idle_cnt_reg + CW'(1);
            end
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_ferr_reg  <= rx_ferr_next;
            rx_perr_reg  <= rx_perr_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_last ? '0 : rx_cnt_reg + CW'(1);
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_ferr_next  = rx_ferr_reg;
        rx_perr_next  = rx_perr_reg;
        rx_push       = 1'b0;
        ferr_evt      = 1'b0;
        perr_evt      = 1'b0;
        case (rx_state_reg)
            ST_IDLE: begin
                rx_cnt_next  = '0;
                rx_bit_next  = '0;
                rx_ferr_next = 1'b0;
                rx_perr_next = 1'b0;
                if (armed_reg && rx_prev_reg && !rx_sync_reg) rx_state_next = ST_START;
            end
            ST_START: begin
                if (rx_cnt_reg == BIT_MID) begin
                    rx_cnt_next   = '0;
                    rx_state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_last) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[width-1:1]};
                    rx_bit_next   = rx_bit_reg + BW'(1);
                    if (rx_bit_reg == LAST_DATA) begin
                        rx_bit_next = '0;
`ifdef BUFF_UART_PARITY_EN
                        rx_state_next = ST_PARITY;
`else
                        rx_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef BUFF_UART_PARITY_EN
            ST_PARITY: begin
                if (rx_last) begin
                    rx_perr_next  = rx_sync_reg != ((^rx_shift_reg) ^ parity_odd);
                    rx_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (rx_last) begin
                    rx_ferr_next = stop_bad;
                    rx_bit_next  = rx_bit_reg + BW'(1);
                    if (rx_bit_reg == LAST_STOP) begin
                        rx_state_next = ST_IDLE;
                        ferr_evt      = stop_bad;
                        perr_evt      = rx_perr_reg;
                        rx_push       = !stop_bad && !rx_perr_reg;
                    end
                end
            end
            default: rx_state_next = ST_IDLE;
        endcase
    end

    buff_uart_fifo #(.width(width), .fifo_length(fifo_length)) u_rx_fifo (
        .clock(clock), .resetn(resetn), .push(rx_push), .pop(rx_pop), .wr_data(rx_shift_reg),
        .rd_data(rx_rd_data), .full(rx_full), .empty(rx_empty));

    // ---------------- sticky flags: a set in the same cycle as a status read wins
    logic overrun_reg, framing_reg, parity_reg, tx_ovf_reg;
    logic [7:0]       status_byte;
    logic [width-1:0] status_word, status_snap_reg;
    rd_sel_t          rd_sel_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overrun_reg <= 1'b0;
            framing_reg <= 1'b0;
            parity_reg  <= 1'b0;
            tx_ovf_reg  <= 1'b0;
        end else begin
            overrun_reg <= (overrun_reg && !stat_rd) || (rx_push && rx_full && !rx_pop);
            framing_reg <= (framing_reg && !stat_rd) || ferr_evt;
            parity_reg  <= (parity_reg  && !stat_rd) || perr_evt;
            tx_ovf_reg  <= (tx_ovf_reg  && !stat_rd) || (tx_wr && tx_full && !tx_pop);
        end
    end

    always_comb begin
        status_byte                   = '0;
        status_byte[STAT_RX_EMPTY]    = rx_empty;
        status_byte[STAT_RX_FULL]     = rx_full;
        status_byte[STAT_TX_EMPTY]    = tx_empty;
        status_byte[STAT_TX_FULL]     = tx_full;
        status_byte[STAT_RX_OVERRUN]  = overrun_reg;
        status_byte[STAT_FRAMING_ERR] = framing_reg;
        status_byte[STAT_PARITY_ERR]  = parity_reg;
        status_byte[STAT_TX_OVERFLOW] = (width >= 8) && tx_ovf_reg;
        status_word                   = width'(status_byte);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_sel_reg      <= RD_ZERO;
            status_snap_reg <= '0;
        end else if (rx_rd) begin
            rd_sel_reg <= rx_empty ? RD_ZERO : RD_RX;
        end else if (stat_rd) begin
            rd_sel_reg      <= RD_STATUS;
            status_snap_reg <= status_word;
        end else if (read_enable) begin
            rd_sel_reg <= RD_ZERO;
        end
    end

    always_comb begin
        case (rd_sel_reg)
            RD_RX:     data_out = rx_rd_data;
            RD_STATUS: data_out = status_snap_reg;
            default:   data_out = '0;
        endcase
    end
endmodule

// File: tb/tb_buff_uart_ctrl.sv
// Directed bench for buff_uart_ctrl: register table, TX/RX frames, overrun, framing, reset abort.
`timescale 1ns/1ps
module tb_buff_uart_ctrl;
    localparam int DIV = 48;
`ifdef BUFF_UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_BITS = 1 + 8 + PB + 1;

    logic       clock = 1'b0;
    logic       resetn, rx, tx, read_enable, write_enable;
    logic [3:0] active_address;
    logic [7:0] data_in, data_out;
    logic [7:0] rd;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    buff_uart_ctrl dut (
        .clock(clock), .resetn(resetn), .rx(rx), .tx(tx),
        .read_enable(read_enable), .write_enable(write_enable),
        .active_address(active_address), .data_in(data_in), .data_out(data_out));

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("check %s value=%0h", name, act);
        end
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clock);
        active_address = a;
        read_enable    = 1'b1;
        @(negedge clock);
        read_enable = 1'b0;
        d = data_out;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        active_address = a;
        data_in        = d;
        write_enable   = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_val);
        @(negedge clock);
        rx = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clock);
        end
        if (PB == 1) begin
            rx = par_val;
            repeat (DIV) @(negedge clock);
        end
        rx = stop_val;
        repeat (DIV) @(negedge clock);
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    function automatic logic exp_tx(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PB == 1 && k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic wait_tx_start(input string name);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check(name, (n < 20), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; rx = 1'b1; read_enable = 1'b0; write_enable = 1'b0;
        active_address = '0; data_in = '0;
        vecs[0] = '{4'd2,  8'h05, "rst_status"};
        vecs[1] = '{4'd0,  8'h00, "rx_empty_read"};
        vecs[2] = '{4'd7,  8'h00, "unmapped_7"};
        vecs[3] = '{4'd15, 8'h00, "unmapped_15"};
        vecs[4] = '{4'd2,  8'h05, "status_again"};

        repeat (5) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_data_out", data_out, 0);
        resetn = 1'b1;
        repeat (60) @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            reg_read(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end

        // single TX frame 0xA5, each bit checked at its first and last clock
        reg_write(4'd1, 8'hA5);
        wait_tx_start("tx_start_seen");
        for (int n = 0; n <= FRAME_BITS*DIV + 5; n++) begin
            if (n < FRAME_BITS*DIV && (n % DIV == 0 || n % DIV == DIV-1))
                check($sformatf("tx_bit%0d_n%0d", n / DIV, n), tx, exp_tx(8'hA5, n / DIV));
            else if (n == FRAME_BITS*DIV + 5)
                check("tx_idle_after", tx, 1);
            @(negedge clock);
        end

        // RX single word
        send_frame(8'h3C, 1'b1, ^8'h3C);
        reg_read(4'd0, rd);
        check("rx_3c", rd, 8'h3C);
        reg_read(4'd2, rd);
        check("status_after_rx", rd, 8'h05);

        // 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            logic [7:0] w;
            w = 8'h10 + 8'(i);
            send_frame(w, 1'b1, ^w);
        end
        reg_read(4'd2, rd);
        check("status_overrun", rd, 8'h16);
        reg_read(4'd2, rd);
        check("status_overrun_clr", rd, 8'h06);
        for (int i = 0; i < 16; i++) begin
            reg_read(4'd0, rd);
            check($sformatf("rx_word%0d", i), rd, 8'h10 + 8'(i));
        end
        reg_read(4'd0, rd);
        check("rx_drained_zero", rd, 8'h00);

        // stop bit 0
        send_frame(8'h55, 1'b0, ^8'h55);
        reg_read(4'd2, rd);
        check("status_framing", rd, 8'h25);
        reg_read(4'd2, rd);
        check("status_framing_clr", rd, 8'h05);

`ifdef BUFF_UART_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0);
        reg_read(4'd2, rd);
        check("status_parity", rd, 8'h45);
`endif

        // 18 back-to-back writes: one goes on the line, 16 fill the FIFO, the last overflows
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            active_address = 4'd1;
            data_in        = 8'hA0 + 8'(i);
            write_enable   = 1'b1;
        end
        @(negedge clock);
        write_enable = 1'b0;
        reg_read(4'd2, rd);
        check("status_tx_overflow", rd, 8'h89);
        repeat (78) @(negedge clock);
        check("tx_low_before_reset", tx, 0);
        resetn = 1'b0;
        #1;
        check("tx_abort", tx, 1);
        check("data_out_in_reset", data_out, 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        reg_read(4'd2, rd);
        check("status_after_reset", rd, 8'h05);
        repeat (60) @(negedge clock);
        check("tx_idle_after_reset", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
